// File: rtl/renode_axi_write_burst_manager.sv
// AXI4 write-burst manager: one command + beat stream in, AW/W/B out, one response back.
// Optional RENODE_AXI_BRESP_TIMEOUT_EN adds a B-channel timeout that reports DECERR.
module renode_axi_write_burst_manager #(
    parameter int AddressWidth       = 32,
    parameter int DataWidth          = 32,
    parameter int TransactionIdWidth = 8,
    parameter int MaxBurstLength     = 256,
    parameter int TimeoutCycles      = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [AddressWidth-1:0]       cmd_addr,
    input  logic [7:0]                    cmd_len,
    input  logic [2:0]                    cmd_size,
    input  logic [1:0]                    cmd_burst,
    input  logic [TransactionIdWidth-1:0] cmd_id,
    input  logic                          data_valid,
    output logic                          data_ready,
    input  logic [DataWidth-1:0]          data,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [1:0]                    rsp_resp,
    output logic [TransactionIdWidth-1:0] rsp_id,
    output logic [TransactionIdWidth-1:0] awid,
    output logic [AddressWidth-1:0]       awaddr,
    output logic [7:0]                    awlen,
    output logic [2:0]                    awsize,
    output logic [1:0]                    awburst,
    output logic                          awlock,
    output logic [3:0]                    awcache,
    output logic [2:0]                    awprot,
    output logic                          awvalid,
    input  logic                          awready,
    output logic [DataWidth-1:0]          wdata,
    output logic [DataWidth/8-1:0]        wstrb,
    output logic                          wlast,
    output logic                          wvalid,
    input  logic                          wready,
    input  logic [TransactionIdWidth-1:0] bid,
    input  logic [1:0]                    bresp,
    input  logic                          bvalid,
    output logic                          bready
);
    localparam int NB     = DataWidth / 8;
    localparam int LOG_NB = $clog2(NB);

    typedef enum logic [2:0] {IDLE, CHECK, ADDR, DATA, RESP, DONE} state_t;
    state_t state;

    logic [AddressWidth-1:0]       c_addr, beat_addr, wrap_bound;
    logic [7:0]                    c_len, beat_cnt;
    logic [2:0]                    c_size;
    logic [1:0]                    c_burst;
    logic [TransactionIdWidth-1:0] c_id;

    logic [AddressWidth-1:0] size_bytes, size_mask, total, last_byte, incr_next, next_addr;
    logic                    illegal;

    always_comb begin
        size_bytes = AddressWidth'(1) << c_size;
        size_mask  = size_bytes - AddressWidth'(1);
        total      = (AddressWidth'(c_len) + AddressWidth'(1)) << c_size;
        last_byte  = (c_addr & ~size_mask) + total - AddressWidth'(1);
        illegal    = (int'(c_size) > LOG_NB)
                   || (int'(c_len) + 1 > MaxBurstLength)
                   || (c_burst == 2'd3)
                   || (c_burst == 2'd2 && (!(c_len inside {8'd1, 8'd3, 8'd7, 8'd15})
                                           || (c_addr & size_mask) != '0))
                   || (c_burst == 2'd1 && c_addr[AddressWidth-1:12] != last_byte[AddressWidth-1:12]);
        incr_next  = (beat_addr & ~size_mask) + size_bytes;
        case (c_burst)
            2'd0:    next_addr = c_addr;
            2'd2:    next_addr = (incr_next == wrap_bound + total) ? wrap_bound : incr_next;
            default: next_addr = incr_next;
        endcase
    end

    // Strobe covers the size-aligned container, minus lanes below an unaligned start byte.
    int addr_off, al_off, sb_int;
    always_comb begin
        addr_off = int'(beat_addr & AddressWidth'(NB - 1));
        al_off   = int'((beat_addr & ~size_mask) & AddressWidth'(NB - 1));
        sb_int   = 1 << c_size;
        wstrb    = '0;
        if (state == DATA)
            for (int i = 0; i < NB; i++)
                if (i >= addr_off && i < al_off + sb_int) wstrb[i] = 1'b1;
    end

    assign wvalid     = (state == DATA) && data_valid;
    assign data_ready = (state == DATA) && wready;
    assign wdata      = (state == DATA) ? data : '0;
    assign wlast      = (state == DATA) && (beat_cnt == c_len);
    assign awlock     = 1'b0;
    assign awcache    = 4'd0;
    assign awprot     = 3'd0;

`ifdef RENODE_AXI_BRESP_TIMEOUT_EN
    localparam int TW = $clog2(TimeoutCycles + 1);
    logic [TW-1:0] to_cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            awvalid    <= 1'b0;
            bready     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_resp   <= '0;
            rsp_id     <= '0;
            awid       <= '0;
            awaddr     <= '0;
            awlen      <= '0;
            awsize     <= '0;
            awburst    <= '0;
            c_addr     <= '0;
            c_len      <= '0;
            c_size     <= '0;
            c_burst    <= '0;
            c_id       <= '0;
            beat_addr  <= '0;
            beat_cnt   <= '0;
            wrap_bound <= '0;
`ifdef RENODE_AXI_BRESP_TIMEOUT_EN
            to_cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    c_addr    <= cmd_addr;
                    c_len     <= cmd_len;
                    c_size    <= cmd_size;
                    c_burst   <= cmd_burst;
                    c_id      <= cmd_id;
                    cmd_ready <= 1'b0;
                    state     <= CHECK;
                end
                CHECK: if (illegal) begin
                    rsp_resp  <= 2'b10;
                    rsp_id    <= c_id;
                    rsp_valid <= 1'b1;
                    state     <= DONE;
                end else begin
                    awaddr     <= c_addr;
                    awlen      <= c_len;
                    awsize     <= c_size;
                    awburst    <= c_burst;
                    awid       <= c_id;
                    awvalid    <= 1'b1;
                    beat_addr  <= c_addr;
                    beat_cnt   <= '0;
                    wrap_bound <= c_addr & ~(total - AddressWidth'(1));
                    state      <= ADDR;
                end
                ADDR: if (awready) begin
                    awvalid <= 1'b0;
                    state   <= DATA;
                end
                DATA: if (data_valid && wready) begin
                    beat_cnt  <= beat_cnt + 8'd1;
                    beat_addr <= next_addr;
                    if (beat_cnt == c_len) begin
                        bready <= 1'b1;
                        state  <= RESP;
`ifdef RENODE_AXI_BRESP_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                    end
                end
                RESP: if (bvalid) begin
                    bready    <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_resp  <= (bid != awid) ? 2'b10 : bresp;
                    rsp_id    <= bid;
                    state     <= DONE;
                end
`ifdef RENODE_AXI_BRESP_TIMEOUT_EN
                else if (to_cnt == TW'(TimeoutCycles - 1)) begin
                    bready    <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_resp  <= 2'b11;
                    rsp_id    <= c_id;
                    state     <= DONE;
                end else begin
                    to_cnt <= to_cnt + TW'(1);
                end
`endif
                DONE: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_renode_axi_write_burst_manager.sv
// Directed bench for renode_axi_write_burst_manager (default build, 32-bit data).
module tb_renode_axi_write_burst_manager;
    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic [7:0]  cmd_id;
    logic        data_valid, data_ready;
    logic [31:0] data;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_resp;
    logic [7:0]  rsp_id, awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [7:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    int n_assert = 0;
    int n_fail   = 0;

    renode_axi_write_burst_manager dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_id(cmd_id),
        .data_valid(data_valid), .data_ready(data_ready), .data(data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp), .rsp_id(rsp_id),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                            input logic [1:0] b, input logic [7:0] id);
        cmd_addr = a; cmd_len = l; cmd_size = s; cmd_burst = b; cmd_id = id; cmd_valid = 1'b1;
        #1;
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        chk("cmd_ready_busy", cmd_ready, 1'b0);
        chk("awvalid_check", awvalid, 1'b0);
    endtask

    task automatic expect_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                             input logic [1:0] b, input logic [7:0] id, input int stall);
        awready = (stall == 0);
        if (stall > 0) begin
            data_valid = 1'b1;
            data = 32'hDEAD_BEEF;
        end
        tick();
        chk("awvalid", awvalid, 1'b1);
        chk("awaddr", awaddr, a);
        chk("awlen", awlen, l);
        chk("awsize", awsize, s);
        chk("awburst", awburst, b);
        chk("awid", awid, id);
        chk("aw_const", {awlock, awcache, awprot}, 8'd0);
        for (int k = 0; k < stall; k++) begin
            chk("w_before_aw", wvalid, 1'b0);
            tick();
            chk("awvalid_stall", awvalid, 1'b1);
            chk("awaddr_stable", awaddr, a);
        end
        awready = 1'b1;
        data_valid = 1'b0;
        if (stall > 0) tick();
        else tick();
        chk("awvalid_drop", awvalid, 1'b0);
    endtask

    task automatic beat(input logic [31:0] d, input logic [3:0] strb, input logic last);
        data = d; data_valid = 1'b1; wready = 1'b1;
        #1;
        chk("wvalid", wvalid, 1'b1);
        chk("data_ready", data_ready, 1'b1);
        chk("wdata", wdata, d);
        chk("wstrb", wstrb, strb);
        chk("wlast", wlast, last);
        tick();
        data_valid = 1'b0;
    endtask

    task automatic finish_b(input logic [7:0] id, input logic [1:0] br, input logic [1:0] want);
        chk("bready_resp", bready, 1'b1);
        chk("wvalid_resp", wvalid, 1'b0);
        bvalid = 1'b1; bid = id; bresp = br;
        tick();
        bvalid = 1'b0;
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_resp", rsp_resp, want);
        chk("rsp_id", rsp_id, id);
        chk("bready_done", bready, 1'b0);
        tick();
        chk("rsp_hold", rsp_valid, 1'b1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_clear", rsp_valid, 1'b0);
        chk("cmd_ready_back", cmd_ready, 1'b1);
    endtask

    task automatic illegal(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b, input logic [7:0] id);
        send_cmd(a, l, s, b, id);
        tick();
        chk("ill_rsp_valid", rsp_valid, 1'b1);
        chk("ill_rsp_resp", rsp_resp, 2'b10);
        chk("ill_rsp_id", rsp_id, id);
        chk("ill_awvalid", awvalid, 1'b0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("ill_awvalid2", awvalid, 1'b0);
        chk("ill_cmd_ready", cmd_ready, 1'b1);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0; cmd_burst = 0;
        cmd_id = 0; data_valid = 0; data = 0; rsp_ready = 0; awready = 0; wready = 0;
        bid = 0; bresp = 0; bvalid = 0;
        tick(); tick();
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_bready", bready, 1'b0);
        chk("rst_data_ready", data_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_awaddr", awaddr, 32'd0);
        chk("rst_wstrb", wstrb, 4'd0);
        chk("rst_wlast", wlast, 1'b0);
        reset = 1'b0;
        tick();

        // INCR aligned, full words
        send_cmd(32'h1000, 8'd3, 3'd2, 2'd1, 8'h5A);
        expect_aw(32'h1000, 8'd3, 3'd2, 2'd1, 8'h5A, 0);
        beat(32'hA000_0000, 4'hF, 1'b0);
        beat(32'hA000_0001, 4'hF, 1'b0);
        beat(32'hA000_0002, 4'hF, 1'b0);
        beat(32'hA000_0003, 4'hF, 1'b1);
        finish_b(8'h5A, 2'b00, 2'b00);

        // Unaligned narrow INCR, EXOKAY passed through
        send_cmd(32'h1001, 8'd2, 3'd0, 2'd1, 8'h11);
        expect_aw(32'h1001, 8'd2, 3'd0, 2'd1, 8'h11, 0);
        beat(32'h0000_1100, 4'h2, 1'b0);
        beat(32'h0011_0000, 4'h4, 1'b0);
        beat(32'h1100_0000, 4'h8, 1'b1);
        finish_b(8'h11, 2'b01, 2'b01);

        // WRAP word burst, AW held off two cycles with data already offered
        send_cmd(32'h2008, 8'd3, 3'd2, 2'd2, 8'h03);
        expect_aw(32'h2008, 8'd3, 3'd2, 2'd2, 8'h03, 2);
        beat(32'hB000_0000, 4'hF, 1'b0);
        beat(32'hB000_0001, 4'hF, 1'b0);
        beat(32'hB000_0002, 4'hF, 1'b0);
        beat(32'hB000_0003, 4'hF, 1'b1);
        finish_b(8'h03, 2'b00, 2'b00);

        // WRAP byte burst: 0x2002, 0x2003, wrap to 0x2000, 0x2001
        send_cmd(32'h2002, 8'd3, 3'd0, 2'd2, 8'h04);
        expect_aw(32'h2002, 8'd3, 3'd0, 2'd2, 8'h04, 0);
        beat(32'h0000_0100, 4'h4, 1'b0);
        beat(32'h0100_0000, 4'h8, 1'b0);
        beat(32'h0000_0001, 4'h1, 1'b0);
        beat(32'h0000_0100, 4'h2, 1'b1);
        finish_b(8'h04, 2'b00, 2'b00);

        // FIXED byte burst stays on one lane
        send_cmd(32'h3001, 8'd2, 3'd0, 2'd0, 8'h06);
        expect_aw(32'h3001, 8'd2, 3'd0, 2'd0, 8'h06, 0);
        beat(32'h0000_0A00, 4'h2, 1'b0);
        beat(32'h0000_0B00, 4'h2, 1'b0);
        beat(32'h0000_0C00, 4'h2, 1'b1);
        finish_b(8'h06, 2'b00, 2'b00);

        // Unaligned word INCR: first beat partial, then full
        send_cmd(32'h1002, 8'd1, 3'd2, 2'd1, 8'h07);
        expect_aw(32'h1002, 8'd1, 3'd2, 2'd1, 8'h07, 0);
        beat(32'h1234_0000, 4'hC, 1'b0);
        beat(32'h5678_9ABC, 4'hF, 1'b1);
        finish_b(8'h07, 2'b10, 2'b10);

        // Illegal commands
        illegal(32'h0FFC, 8'd1, 3'd2, 2'd1, 8'h21);
        illegal(32'h1000, 8'd0, 3'd3, 2'd1, 8'h22);
        illegal(32'h1000, 8'd0, 3'd2, 2'd3, 8'h23);
        illegal(32'h2000, 8'd2, 3'd2, 2'd2, 8'h24);
        illegal(32'h2002, 8'd3, 3'd2, 2'd2, 8'h25);

        // BID mismatch forces SLVERR
        send_cmd(32'h1000, 8'd0, 3'd2, 2'd1, 8'h07);
        expect_aw(32'h1000, 8'd0, 3'd2, 2'd1, 8'h07, 0);
        beat(32'hCAFE_F00D, 4'hF, 1'b1);
        chk("mm_bready", bready, 1'b1);
        bvalid = 1'b1; bid = 8'h08; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        chk("mm_rsp_valid", rsp_valid, 1'b1);
        chk("mm_rsp_resp", rsp_resp, 2'b10);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // W backpressure at beat 1
        send_cmd(32'h1001, 8'd3, 3'd0, 2'd1, 8'h44);
        expect_aw(32'h1001, 8'd3, 3'd0, 2'd1, 8'h44, 0);
        beat(32'h0000_0100, 4'h2, 1'b0);
        data = 32'h0055_0000; data_valid = 1'b1; wready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_data_ready", data_ready, 1'b0);
            chk("bp_wdata", wdata, 32'h0055_0000);
            chk("bp_wstrb", wstrb, 4'h4);
            chk("bp_wlast", wlast, 1'b0);
            tick();
        end
        beat(32'h0055_0000, 4'h4, 1'b0);
        beat(32'h6600_0000, 4'h8, 1'b0);
        beat(32'h0000_0077, 4'h1, 1'b1);
        finish_b(8'h44, 2'b00, 2'b00);

        // Reset during beat 2 of 4
        send_cmd(32'h1000, 8'd3, 3'd2, 2'd1, 8'h09);
        expect_aw(32'h1000, 8'd3, 3'd2, 2'd1, 8'h09, 0);
        beat(32'hD000_0000, 4'hF, 1'b0);
        beat(32'hD000_0001, 4'hF, 1'b0);
        data = 32'hD000_0002; data_valid = 1'b1; wready = 1'b1; reset = 1'b1;
        tick();
        chk("ra_awvalid", awvalid, 1'b0);
        chk("ra_wvalid", wvalid, 1'b0);
        chk("ra_cmd_ready", cmd_ready, 1'b1);
        chk("ra_rsp_valid", rsp_valid, 1'b0);
        reset = 1'b0; data_valid = 1'b0;
        tick(); tick();
        chk("ra_no_rsp", rsp_valid, 1'b0);
        chk("ra_no_bready", bready, 1'b0);

        // Clean burst after abort
        send_cmd(32'h4000, 8'd0, 3'd2, 2'd1, 8'h0A);
        expect_aw(32'h4000, 8'd0, 3'd2, 2'd1, 8'h0A, 0);
        beat(32'hE000_0000, 4'hF, 1'b1);
        finish_b(8'h0A, 2'b00, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
